// File: rtl/n64_pi_initiator_pkg.sv
// Shared types and constants for the PI initiator: state encoding, burst boundary, default timing.
// No logic; imported by the interface users and the initiator modules.
// Helper functions are pure combinational.
package n64_pi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALE_RISE,
    ADDR_H,
    ADDR_L,
    SETTLE,
    LOW,
    HIGH,
    DONE
  } e_pi_init_state;

  localparam int unsigned PI_BURST_BOUNDARY = 512;

  localparam int unsigned T_ALE_DEF    = 4;
  localparam int unsigned T_SETTLE_DEF = 4;
  localparam int unsigned T_LOW_DEF    = 6;
  localparam int unsigned T_HIGH_DEF   = 3;

  // A zero length field encodes a full 256-word burst.
  function automatic logic [8:0] pi_len_words(input logic [8:0] len);
    return (len == 9'd0) ? 9'd256 : len;
  endfunction

  // True when a burst starting at this offset would run past the next 512-byte line.
  function automatic logic pi_crosses_boundary(input logic [8:0] addr_lo, input logic [8:0] words);
    logic [10:0] start_off;
    logic [10:0] byte_len;
    start_off = {2'b00, addr_lo & 9'h1FE};
    byte_len  = {1'b0, words, 1'b0};
    return (start_off + byte_len) > 11'(PI_BURST_BOUNDARY);
  endfunction

endpackage

// File: rtl/n64_pi_initiator_if.sv
// Bundle of request, data-stream and PI pad signals between the initiator and its environment.
// No latency of its own; pure wiring.
// master = the initiator, slave = requester plus cart-side responder.
// err_boundary exists only when N64_PI_INITIATOR_BOUNDARY_SPLIT_EN is undefined.
interface n64_pi_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [8:0]  req_length;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        n64_pi_alel;
  logic        n64_pi_aleh;
  logic        n64_pi_read;
  logic        n64_pi_write;
  logic [15:0] n64_pi_ad_out;
  logic        n64_pi_ad_oe;
  logic [15:0] n64_pi_ad_in;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
  logic        err_boundary;
`endif

  modport master (
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    output err_boundary,
`endif
    input  req_valid, req_write, req_address, req_length,
    input  wr_data, wr_valid, n64_pi_ad_in,
    output req_ready, wr_ready, rd_data, rd_valid, done,
    output n64_pi_alel, n64_pi_aleh, n64_pi_read, n64_pi_write,
    output n64_pi_ad_out, n64_pi_ad_oe
  );

  modport slave (
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    input  err_boundary,
`endif
    output req_valid, req_write, req_address, req_length,
    output wr_data, wr_valid, n64_pi_ad_in,
    input  req_ready, wr_ready, rd_data, rd_valid, done,
    input  n64_pi_alel, n64_pi_aleh, n64_pi_read, n64_pi_write,
    input  n64_pi_ad_out, n64_pi_ad_oe
  );

endinterface

// File: rtl/n64_pi_initiator_timer.sv
// Loadable 8-bit down-counter with zero flag, shared by every timed PI phase.
// Load takes effect next cycle; counts down one per cycle and parks at zero.
// No backpressure: the FSM simply holds its state while zero is high and it cannot move.
module n64_pi_initiator_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_vld,
  input  logic [7:0] load_dat,
  output logic       zero
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: reload wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_vld) begin
      cnt_d = load_dat;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/n64_pi_initiator.sv
// PI cartridge-bus master emulating the RCP: address phases on ALEH/ALEL, then strobed 16-bit words.
// Latency: 1+2*T_ALE+T_SETTLE cycles from accept to first strobe, T_LOW+T_HIGH per word, 1-cycle done.
// Backpressure: write slots hold the strobe high until wr_valid; req_ready is low for the whole burst.
// Build option N64_PI_INITIATOR_BOUNDARY_SPLIT_EN: re-issue the address at each 512-byte line;
// undefined, a crossing burst runs linearly and sets sticky err_boundary at acceptance.
module n64_pi_initiator
  import n64_pi_pkg::*;
#(
  parameter int unsigned T_ALE    = T_ALE_DEF,
  parameter int unsigned T_SETTLE = T_SETTLE_DEF,
  parameter int unsigned T_LOW    = T_LOW_DEF,
  parameter int unsigned T_HIGH   = T_HIGH_DEF
) (
  input logic               clk,
  input logic               reset_n,
  n64_pi_initiator_if.master pi
);

  e_pi_init_state state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [8:0]     rem_q, rem_d;
  logic           wr_q, wr_d;
  logic [15:0]    wdat_q, wdat_d;
  logic [15:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
  logic           err_q, err_d;
`endif

  logic           tmr_load;
  logic [7:0]     tmr_val;
  logic           tmr_zero;
  logic           wr_ready;

  logic           alel, aleh, rd_n, wr_n, ad_oe, req_ready, done;
  logic [15:0]    ad_out;

  // Each state lasts N cycles, so the timer is loaded with N-1 on entry.
  function automatic logic [7:0] state_dur(input e_pi_init_state s);
    case (s)
      ADDR_H, ADDR_L: return 8'(T_ALE - 1);
      SETTLE:         return 8'(T_SETTLE - 1);
      LOW:            return 8'(T_LOW - 1);
      HIGH:           return 8'(T_HIGH - 1);
      default:        return 8'd0;
    endcase
  endfunction

  n64_pi_initiator_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_vld (tmr_load),
    .load_dat (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, burst bookkeeping and write-slot handshake.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_d       = wr_q;
    wdat_d     = wdat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pi.req_valid) begin
          addr_d  = pi.req_address & ~32'd1;
          wr_d    = pi.req_write;
          rem_d   = pi_len_words(pi.req_length);
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
          err_d   = pi_crosses_boundary(pi.req_address[8:0], pi_len_words(pi.req_length));
`endif
          state_d = ALE_RISE;
        end
      end
      ALE_RISE: if (tmr_zero) state_d = ADDR_H;
      ADDR_H:   if (tmr_zero) state_d = ADDR_L;
      ADDR_L:   if (tmr_zero) state_d = SETTLE;
      SETTLE: begin
        if (tmr_zero) begin
          if (!wr_q) begin
            state_d = LOW;
          end else if (pi.wr_valid) begin
            wr_ready = 1'b1;
            wdat_d   = pi.wr_data;
            state_d  = LOW;
          end
        end
      end
      LOW: begin
        if (tmr_zero) begin
          if (!wr_q) begin
            rd_data_d  = pi.n64_pi_ad_in;
            rd_valid_d = 1'b1;
          end
          addr_d  = addr_q + 32'd2;
          rem_d   = rem_q - 9'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          if (rem_q == 9'd0) begin
            state_d = DONE;
          end
`ifdef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
          else if (addr_q[8:0] == 9'd0) begin
            state_d = ALE_RISE;
          end
`endif
          else if (!wr_q) begin
            state_d = LOW;
          end else if (pi.wr_valid) begin
            wr_ready = 1'b1;
            wdat_d   = pi.wr_data;
            state_d  = LOW;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tmr_load = (state_d != state_q);
    tmr_val  = state_dur(state_d);
  end

  // Pad and status decode; outputs follow the state register so reset clears them at once.
  always_comb begin
    alel      = 1'b0;
    aleh      = 1'b0;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    ad_out    = 16'h0000;
    ad_oe     = 1'b0;
    req_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:     req_ready = 1'b1;
      ALE_RISE: alel = 1'b1;
      ADDR_H: begin
        alel   = 1'b1;
        aleh   = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q[31:16];
      end
      ADDR_L: begin
        alel   = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q[15:0];
      end
      SETTLE: begin
        ad_oe  = wr_q;
        ad_out = wr_q ? addr_q[15:0] : 16'h0000;
      end
      LOW: begin
        rd_n   = wr_q;
        wr_n   = !wr_q;
        ad_oe  = wr_q;
        ad_out = wr_q ? wdat_q : 16'h0000;
      end
      HIGH: begin
        ad_oe  = wr_q;
        ad_out = wr_q ? wdat_q : 16'h0000;
      end
      DONE:    done = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // State and datapath registers; a reset mid-burst discards the burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      rem_q      <= 9'd0;
      wr_q       <= 1'b0;
      wdat_q     <= 16'h0000;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wr_q       <= wr_d;
      wdat_q     <= wdat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign pi.req_ready     = req_ready;
  assign pi.wr_ready      = wr_ready;
  assign pi.rd_data       = rd_data_q;
  assign pi.rd_valid      = rd_valid_q;
  assign pi.done          = done;
  assign pi.n64_pi_alel   = alel;
  assign pi.n64_pi_aleh   = aleh;
  assign pi.n64_pi_read   = rd_n;
  assign pi.n64_pi_write  = wr_n;
  assign pi.n64_pi_ad_out = ad_out;
  assign pi.n64_pi_ad_oe  = ad_oe;
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
  assign pi.err_boundary  = err_q;
`endif

endmodule

// File: tb/tb_n64_pi_initiator.sv
// Directed bench for the PI initiator: reads, writes, write stall, boundary, 256-word and reset cases.
// A negedge monitor plays the cart responder and logs addresses, strobes and read words.
module tb_n64_pi_initiator;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc_now = 0;
  int   acc_cyc = 0;

  n64_pi_initiator_if pi ();

  n64_pi_initiator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pi      (pi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // ---------------- responder / monitor ----------------
  logic [31:0] mon_addr = 32'd0;
  logic [15:0] rd_idx = 16'd0;
  int          low_cnt = 0;
  logic        alel_p = 1'b0, read_p = 1'b1, write_p = 1'b1;
  logic [31:0] aphase_q[$];
  logic [15:0] wr_seen[$];
  logic [31:0] wr_addr[$];
  int          low_lens[$];
  logic [15:0] rd_got[$];

  initial pi.n64_pi_ad_in = 16'h1111;

  always @(negedge clk) begin
    if (pi.req_valid && pi.req_ready) rd_idx = 16'd0;
    if (pi.n64_pi_alel && pi.n64_pi_aleh) mon_addr[31:16] = pi.n64_pi_ad_out;
    if (pi.n64_pi_alel && !pi.n64_pi_aleh && pi.n64_pi_ad_oe) mon_addr[15:0] = pi.n64_pi_ad_out;
    if (alel_p && !pi.n64_pi_alel) aphase_q.push_back(mon_addr);
    if (!pi.n64_pi_write && write_p) begin
      wr_seen.push_back(pi.n64_pi_ad_out);
      wr_addr.push_back(mon_addr);
    end
    if (!pi.n64_pi_write || !pi.n64_pi_read) low_cnt++;
    if ((pi.n64_pi_write && !write_p) || (pi.n64_pi_read && !read_p)) begin
      low_lens.push_back(low_cnt);
      low_cnt  = 0;
      mon_addr = mon_addr + 32'd2;
      if (pi.n64_pi_read && !read_p) rd_idx = rd_idx + 16'd1;
    end
    if (pi.rd_valid) rd_got.push_back(pi.rd_data);
    pi.n64_pi_ad_in = 16'h1111 * (rd_idx + 16'd1);
    alel_p  = pi.n64_pi_alel;
    read_p  = pi.n64_pi_read;
    write_p = pi.n64_pi_write;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [8:0] l);
    @(negedge clk);
    pi.req_write   = w;
    pi.req_address = a;
    pi.req_length  = l;
    pi.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    pi.req_valid = 1'b0;
    acc_cyc      = cyc_now;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pi.done) begin
        lat = cyc_now - acc_cyc + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic push_word(input logic [15:0] d, input int gap, output int stray_rdy,
                           output logic ok, output logic wr_hi_end);
    stray_rdy = 0;
    wr_hi_end = 1'b1;
    pi.wr_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (pi.wr_ready) stray_rdy++;
      wr_hi_end = pi.n64_pi_write;
      @(posedge clk);
      #1;
    end
    pi.wr_data  = d;
    pi.wr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pi.wr_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pi.wr_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   lat, cnt, b_rd, b_ap, b_wr, b_ll, stray, falls, dseen;
    logic ok, whi, rprev;

    reset_n = 1'b0;
    pi.req_valid = 1'b0; pi.req_write = 1'b0; pi.req_address = 32'd0; pi.req_length = 9'd0;
    pi.wr_valid = 1'b0;  pi.wr_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_alel",  32'(pi.n64_pi_alel), 0);
    chk("rst_aleh",  32'(pi.n64_pi_aleh), 0);
    chk("rst_read",  32'(pi.n64_pi_read), 1);
    chk("rst_write", 32'(pi.n64_pi_write), 1);
    chk("rst_ad",    {15'd0, pi.n64_pi_ad_oe, pi.n64_pi_ad_out}, 0);
    chk("rst_rdy",   32'(pi.req_ready), 1);
    chk("rst_strb",  {29'd0, pi.rd_valid, pi.wr_ready, pi.done}, 0);
    reset_n = 1'b1;

    // Read burst of four words.
    b_rd = rd_got.size(); b_ap = aphase_q.size(); b_ll = low_lens.size();
    issue(1'b0, 32'h1000_0000, 9'd4);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!pi.n64_pi_read) begin cnt = cyc_now - acc_cyc + 1; break; end
    end
    chk("rd_first_low", cnt, 14);
    chk("rd_busy_rdy", 32'(pi.req_ready), 0);
    wait_done(200, lat);
    chk("rd_done_lat", lat, 50);
    chk("rd_idle_rdy", 32'(pi.req_ready), 1);
    chk("rd_count", rd_got.size() - b_rd, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rd_word%0d", i), 32'(rd_got[b_rd + i]), 32'h1111 * (i + 1));
    chk("rd_addr", aphase_q[b_ap], 32'h1000_0000);
    chk("rd_low_len0", low_lens[b_ll], 6);
    chk("rd_low_len3", low_lens[b_ll + 3], 6);

    // Write burst of two words, no stall.
    b_wr = wr_seen.size(); b_ll = low_lens.size();
    issue(1'b1, 32'h1000_0100, 9'd2);
    push_word(16'hABCD, 0, stray, ok, whi);
    chk("wr_hs0", 32'(ok), 1);
    push_word(16'h1234, 0, stray, ok, whi);
    chk("wr_hs1", 32'(ok), 1);
    wait_done(200, lat);
    chk("wr_done_lat", lat, 32);
    chk("wr_count", wr_seen.size() - b_wr, 2);
    chk("wr_dat0", 32'(wr_seen[b_wr]), 32'hABCD);
    chk("wr_dat1", 32'(wr_seen[b_wr + 1]), 32'h1234);
    chk("wr_adr0", wr_addr[b_wr], 32'h1000_0100);
    chk("wr_adr1", wr_addr[b_wr + 1], 32'h1000_0102);
    chk("wr_low_len0", low_lens[b_ll], 6);
    chk("wr_low_len1", low_lens[b_ll + 1], 6);

    // Write with wr_valid withheld for 14 cycles before word 2.
    b_wr = wr_seen.size();
    issue(1'b1, 32'h1000_0200, 9'd2);
    push_word(16'h5555, 0, stray, ok, whi);
    chk("st_hs0", 32'(ok), 1);
    push_word(16'h6666, 14, stray, ok, whi);
    chk("st_no_rdy", stray, 0);
    chk("st_write_hi", 32'(whi), 1);
    chk("st_hs1", 32'(ok), 1);
    wait_done(200, lat);
    chk("st_done_lat", lat, 38);
    chk("st_dat1", 32'(wr_seen[b_wr + 1]), 32'h6666);
    chk("st_adr1", wr_addr[b_wr + 1], 32'h1000_0202);

    // Burst crossing a 512-byte line.
    b_rd = rd_got.size(); b_ap = aphase_q.size();
    issue(1'b0, 32'h1000_01FC, 9'd4);
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    chk("bd_err_set", 32'(pi.err_boundary), 1);
`endif
    wait_done(300, lat);
    chk("bd_count", rd_got.size() - b_rd, 4);
    chk("bd_word3", 32'(rd_got[b_rd + 3]), 32'h4444);
`ifdef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    chk("bd_done_lat", lat, 63);
    chk("bd_phases", aphase_q.size() - b_ap, 2);
    chk("bd_addr2", aphase_q[b_ap + 1], 32'h1000_0200);
`else
    chk("bd_done_lat", lat, 50);
    chk("bd_phases", aphase_q.size() - b_ap, 1);
    chk("bd_addr1", aphase_q[b_ap], 32'h1000_01FC);
`endif

    // Length 0 means 256 words; aligned start so no line crossing.
    b_rd = rd_got.size(); b_ap = aphase_q.size();
    issue(1'b0, 32'h1000_0000, 9'd0);
`ifndef N64_PI_INITIATOR_BOUNDARY_SPLIT_EN
    chk("l0_err_clr", 32'(pi.err_boundary), 0);
`endif
    wait_done(3000, lat);
    chk("l0_done_lat", lat, 2318);
    chk("l0_count", rd_got.size() - b_rd, 256);
    chk("l0_phases", aphase_q.size() - b_ap, 1);

    // Reset during LOW of word 3.
    issue(1'b0, 32'h1000_0000, 9'd4);
    falls = 0; rprev = 1'b1;
    for (int i = 0; i < 200 && falls < 3; i++) begin
      @(negedge clk);
      if (rprev && !pi.n64_pi_read) falls++;
      rprev = pi.n64_pi_read;
    end
    chk("rs_reached_w3", falls, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("rs_read", 32'(pi.n64_pi_read), 1);
    chk("rs_oe", 32'(pi.n64_pi_ad_oe), 0);
    chk("rs_rdy", 32'(pi.req_ready), 1);
    chk("rs_alel", 32'(pi.n64_pi_alel), 0);
    dseen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      if (pi.done) dseen++;
    end
    chk("rs_no_done", dseen, 0);
    chk("rs_idle_rdy", 32'(pi.req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
